// File: rtl/multi_channel_clock_divider.sv
// multi_channel_clock_divider: bank of independent phase-accumulator clock dividers with tick strobes
module multi_channel_clock_divider #(
    parameter int NUM_CHANNELS = 4,
    parameter int ACC_WIDTH = 28,
    parameter int CHAN_BITS = 2,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = {1'b1, {(ACC_WIDTH-1){1'b0}}}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [CHAN_BITS-1:0]    cfg_chan,
    input  logic [ACC_WIDTH-1:0]    cfg_inc,
    input  logic [NUM_CHANNELS-1:0] chan_en,
    input  logic [NUM_CHANNELS-1:0] phase_rst,
    output logic [NUM_CHANNELS-1:0] cout,
    output logic [NUM_CHANNELS-1:0] tick
);
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [ACC_WIDTH-1:0] acc;
        logic [ACC_WIDTH-1:0] inc;
        logic                 tick_q;
        logic [ACC_WIDTH:0]   sum;
        logic                 we;
        assign sum = {1'b0, acc} + {1'b0, inc};
        assign we = cfg_we && (cfg_chan == CHAN_BITS'(i));
        assign cout[i] = acc[ACC_WIDTH-1];
        assign tick[i] = tick_q;
        // accumulate, hold or phase-clear; carry out of the sum becomes the tick
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc    <= '0;
                tick_q <= 1'b0;
            end else begin
                acc    <= phase_rst[i] ? '0 : chan_en[i] ? sum[ACC_WIDTH-1:0] : acc;
                tick_q <= !phase_rst[i] && chan_en[i] && sum[ACC_WIDTH];
            end
        end
        // increment register; the new rate takes effect from the following edge
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) inc <= DEFAULT_INC;
            else if (we) inc <= cfg_inc;
        end
    end
endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// tb_multi_channel_clock_divider: directed self-checking bench for the divider bank
module tb_multi_channel_clock_divider;
    logic       clk = 0, rst_n = 0, cfg_we = 0, cfg_we3 = 0;
    logic [1:0] cfg_chan = 0;
    logic [7:0] cfg_inc = 0;
    logic [3:0] chan_en = 0, phase_rst = 0, cout, tick;
    logic [2:0] phase_rst3 = 0, cout3, tick3;
    int n_cmp = 0, n_err = 0, nt;
    logic [3:0] c2 [4] = '{4'hD, 4'h2, 4'hF, 4'h0};
    logic [3:0] t2 [4] = '{4'h0, 4'hD, 4'h0, 4'hF};
    logic c3 [7] = '{0, 1, 1, 0, 1, 1, 0};
    logic t3 [7] = '{0, 0, 0, 1, 0, 0, 1};
    logic c4 [5] = '{1, 1, 1, 0, 0};
    logic t4 [5] = '{0, 0, 0, 1, 0};
    logic c6 [4] = '{1, 1, 1, 0};
    logic t6 [4] = '{0, 0, 0, 1};

    always #5 clk = ~clk;

    multi_channel_clock_divider #(.NUM_CHANNELS(4), .ACC_WIDTH(8), .CHAN_BITS(2), .DEFAULT_INC(8'd128)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_inc(cfg_inc),
        .chan_en(chan_en), .phase_rst(phase_rst), .cout(cout), .tick(tick)
    );

    multi_channel_clock_divider #(.NUM_CHANNELS(3), .ACC_WIDTH(8), .CHAN_BITS(2), .DEFAULT_INC(8'd128)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we3), .cfg_chan(cfg_chan), .cfg_inc(cfg_inc),
        .chan_en(3'b111), .phase_rst(phase_rst3), .cout(cout3), .tick(tick3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        chan_en = 4'hF;
        repeat (3) begin
            step();
            chk("rst_cout", cout, 4'h0);
            chk("rst_tick", tick, 4'h0);
        end
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("div2_cout", cout, (k % 2 == 0) ? 4'hF : 4'h0);
            chk("div2_tick", tick, (k % 2 == 0) ? 4'h0 : 4'hF);
        end
        phase_rst = 4'hF; cfg_we = 1; cfg_chan = 1; cfg_inc = 64;
        step();
        phase_rst = 0; cfg_we = 0;
        chk("prst_cout", cout, 4'h0);
        chk("prst_tick", tick, 4'h0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("div4_cout", cout, c2[k % 4]);
            chk("div4_tick", tick, t2[k % 4]);
        end
        phase_rst = 4'b0100; cfg_we = 1; cfg_chan = 2; cfg_inc = 85;
        step();
        phase_rst = 0; cfg_we = 0;
        chk("frac_start", {tick[2], cout[2]}, 2'b00);
        for (int k = 0; k < 7; k++) begin
            step();
            chk("frac_cout", cout[2], c3[k]);
            chk("frac_tick", tick[2], t3[k]);
        end
        nt = 0;
        repeat (256) begin
            step();
            nt += int'(tick[2]);
        end
        chk("frac_count", nt, 85);
        phase_rst = 4'b0001; cfg_we = 1; cfg_chan = 0; cfg_inc = 64;
        step();
        phase_rst = 0; cfg_we = 0;
        chk("rate_zero", cout[0], 1'b0);
        step();
        chk("rate_64", {tick[0], cout[0]}, 2'b00);
        cfg_we = 1; cfg_inc = 32;
        step();
        cfg_we = 0;
        chk("rate_oldinc", {tick[0], cout[0]}, 2'b01);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rate_cout", cout[0], c4[k]);
            chk("rate_tick", tick[0], t4[k]);
        end
        cfg_we = 1; cfg_chan = 1; cfg_inc = 32;
        step();
        cfg_chan = 2;
        step();
        cfg_chan = 3; phase_rst = 4'hF;
        step();
        cfg_we = 0; phase_rst = 0;
        chk("align_cout", cout, 4'h0);
        chk("align_tick", tick, 4'h0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("align_run_cout", cout, (k >= 3 && k < 7) ? 4'hF : 4'h0);
            chk("align_run_tick", tick, (k == 7) ? 4'hF : 4'h0);
        end
        repeat (4) step();
        chk("pre_hold", cout, 4'hF);
        chan_en = 4'b0111;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("hold_cout", cout[3], 1'b1);
            chk("hold_tick", tick[3], 1'b0);
        end
        chan_en = 4'hF;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("resume_cout", cout[3], c6[k]);
            chk("resume_tick", tick[3], t6[k]);
        end
        repeat (2) step();
        chk("mid_cout", cout, 4'h7);
        chk("mid_tick", tick, 4'h0);
        cfg_we3 = 1; cfg_chan = 3; cfg_inc = 64; phase_rst3 = 3'b111;
        step();
        cfg_we3 = 0; phase_rst3 = 0;
        chk("oob_start", {tick3, cout3}, 6'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("oob_cout", cout3, (k % 2 == 0) ? 3'h7 : 3'h0);
            chk("oob_tick", tick3, (k % 2 == 0) ? 3'h0 : 3'h7);
        end
        rst_n = 0;
        #2;
        chk("async_cout", cout, 4'h0);
        chk("async_tick", tick, 4'h0);
        step();
        chk("held_rst", {tick, cout}, 8'h0);
        rst_n = 1;
        step();
        chk("rerun_cout", cout, 4'hF);
        chk("rerun_tick", tick, 4'h0);
        step();
        chk("rerun_cout2", cout, 4'h0);
        chk("rerun_tick2", tick, 4'hF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
